// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered loads, leading-zero
// blanking and per-digit decimal points. Define SSEG_DIM_EN to add PWM brightness control.
module sseg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned TICK_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    enable,
`ifdef SSEG_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   SSEG_AN,
    output logic [7:0]              SSEG_CA,
    output logic                    frame_done
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] TickMax = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] LastIdx = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q;
    logic [IW-1:0]           idx_q;
    logic [4*NUM_DIGITS-1:0] disp_val_q;
    logic [NUM_DIGITS-1:0]   disp_dp_q;
    logic [4*NUM_DIGITS-1:0] pend_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic                    pend_flag_q;

    logic                  tick;
    logic                  boundary;
    logic [3:0]            nib;
    logic                  dp_sel;
    logic                  blank;
    logic                  lz;
    logic [NUM_DIGITS-1:0] an_sel;
    logic                  an_on;

    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        hex_glyph = 7'h7F;
        unique case (h)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            4'hF: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign tick     = (presc_q == TickMax);
    assign boundary = tick && (idx_q == LastIdx);

    // Walk from the top digit down so lz means "this digit and all above are zero".
    always_comb begin
        nib    = 4'h0;
        dp_sel = 1'b0;
        blank  = 1'b0;
        an_sel = '1;
        lz     = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            lz = lz && (disp_val_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                nib       = disp_val_q[4*i +: 4];
                dp_sel    = disp_dp_q[i];
                blank     = blank_lz && lz && (i != 0);
                an_sel[i] = 1'b0;
            end
        end
    end

`ifdef SSEG_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= 4'h0;
        else     pwm_cnt <= pwm_cnt + 4'h1;
    end

    assign an_on = (pwm_cnt <= brightness);
`else
    assign an_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) idx_q <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
            if (boundary && pend_flag_q) begin
                disp_val_q  <= pend_val_q;
                disp_dp_q   <= pend_dp_q;
                pend_flag_q <= 1'b0;
            end
            // A load in the boundary cycle lands in pending after the old contents commit.
            if (load) begin
                pend_val_q  <= value;
                pend_dp_q   <= dp_in;
                pend_flag_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            SSEG_AN    <= '1;
            SSEG_CA    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (!enable) begin
                SSEG_AN <= '1;
                SSEG_CA <= 8'hFF;
            end else begin
                SSEG_AN <= an_on ? an_sel : '1;
                SSEG_CA <= {~dp_sel, blank ? 7'h7F : hex_glyph(nib)};
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: a driver pushes the expected outputs of each clock edge,
// derived from elapsed cycles and the load history; a monitor pops and compares every edge.
module tb_sseg_scan_ctrl;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int FRAME = N * TD;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   value;
    logic          load;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic          enable;
    logic [3:0]    SSEG_AN;
    logic [7:0]    SSEG_CA;
    logic          frame_done;
`ifdef SSEG_DIM_EN
    logic [3:0]    brightness = 4'hF;
`endif

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .NUM_DIGITS(N),
        .TICK_DIV  (TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .enable    (enable),
`ifdef SSEG_DIM_EN
        .brightness(brightness),
`endif
        .SSEG_AN   (SSEG_AN),
        .SSEG_CA   (SSEG_CA),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] ca;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: edges since reset, active and pending buffers.
    int          n;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_ddp, m_pdp;
    logic        m_pf;

    task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
        exp_t        e;
        int          ix;
        logic [3:0]  nibv;
        logic [7:0]  g;
        logic [15:0] upper;
        logic        bnd;
        @(negedge clk);
        rst   = r;
        load  = ld;
        value = v;
        dp_in = d;
        if (r) begin
            e.an = 4'hF; e.ca = 8'hFF; e.fd = 1'b0;
            n = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pf = 1'b0;
        end else begin
            ix  = (n / TD) % N;
            bnd = ((n + 1) % FRAME) == 0;
            if (!enable) begin
                e.an = 4'hF; e.ca = 8'hFF;
            end else begin
                nibv  = m_disp[4*ix +: 4];
                g     = glyph[nibv];
                upper = m_disp >> (4 * ix);
                e.an  = ~(4'b0001 << ix);
                e.ca  = {~m_ddp[ix], (blank_lz && ix > 0 && upper == 16'h0) ? 7'h7F : g[6:0]};
            end
            e.fd = bnd;
            if (bnd && m_pf) begin
                m_disp = m_pend; m_ddp = m_pdp; m_pf = 1'b0;
            end
            if (ld) begin
                m_pend = v; m_pdp = d; m_pf = 1'b1;
            end
            n++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic wait_idx(input int i);
        while (((n / TD) % N) != i) idle(1);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (SSEG_AN !== mon_e.an || SSEG_CA !== mon_e.ca || frame_done !== mon_e.fd) begin
                errors++;
                $display("FAIL scan t=%0t got an=%h ca=%h fd=%b expected an=%h ca=%h fd=%b",
                         $time, SSEG_AN, SSEG_CA, frame_done, mon_e.an, mon_e.ca, mon_e.fd);
            end
        end
    end

    initial begin
        int          k;
        logic [15:0] rv;
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0; enable = 1'b1;
        n = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pf = 1'b0;

        step(1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        // Basic scan of 1234
        step(1'b0, 1'b1, 16'h1234, 4'h0);
        idle(3 * FRAME);
        // Double buffering: load mid-frame, then a load exactly in the boundary cycle
        wait_idx(1);
        step(1'b0, 1'b1, 16'hABCD, 4'h0);
        idle(2 * FRAME);
        while (((n + 1) % FRAME) != 0) idle(1);
        step(1'b0, 1'b1, 16'h5678, 4'hA);
        idle(2 * FRAME);
        // Leading-zero blanking
        blank_lz = 1'b1;
        step(1'b0, 1'b1, 16'h0050, 4'h0);
        idle(2 * FRAME);
        step(1'b0, 1'b1, 16'h0000, 4'h0);
        idle(2 * FRAME);
        blank_lz = 1'b0;
        // Decimal point and enable
        step(1'b0, 1'b1, 16'h8888, 4'b0001);
        idle(2 * FRAME);
        enable = 1'b0;
        idle(5);
        enable = 1'b1;
        idle(FRAME);
        // Reset mid-frame with a pending load
        wait_idx(0);
        step(1'b0, 1'b1, 16'h9999, 4'hF);
        wait_idx(2);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        idle(2 * FRAME);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            k  = $urandom_range(0, 4);
            rv = 16'($urandom) >> (4 * k);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, rv, 4'($urandom));
        end

        #5;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending expectations required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Parametrised, time-multiplexed seven-segment display controller for the GPIO subsystem. It displays a NUM_DIGITS-nibble hex value (e.g. CPU writeback) by scanning one digit at a time across shared cathodes. Load requests are double-buffered, so the displayed value only changes on a frame boundary. It adds leading-zero blanking, per-digit decimal points and a frame-done strobe.

Parameters:
NUM_DIGITS, 8, number of digits/anodes driven (legal range 1..8)
TICK_DIV, 100000, clk cycles per digit slot (legal minimum 2); 100 MHz / 1e5 gives 1 kHz digit rate

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
value  input  4*NUM_DIGITS  hex value; nibble i is shown on digit i (digit 0 = rightmost)
load  input  1  one-cycle strobe; captures value and dp_in into the pending buffer
dp_in  input  NUM_DIGITS  decimal-point enables per digit (1 = lit), captured with load
blank_lz  input  1  1 = blank leading-zero digits
enable  input  1  0 = all digits dark; counters keep running
SSEG_AN  output  NUM_DIGITS  anodes, active-low, one-hot-low while scanning
SSEG_CA  output  8  cathodes, active-low; [6:0] = {g,f,e,d,c,b,a}, [7] = DP
frame_done  output  1  one-cycle pulse each time the scan wraps from the last digit to digit 0

Behaviour:
- Reset, synchronous and active-high, is sampled on the rising edge of clk. Reset values:
  - SSEG_AN = all 1s; SSEG_CA = 8'hFF; frame_done = 0.
  - prescaler = 0; digit index = 0.
  - disp_val = 0 and disp_dp = 0 (the active buffer).
  - pend_val = 0, pend_dp = 0, pend_flag = 0 (the pending buffer).
- Reset asserted mid-frame aborts the scan immediately and discards any pending load.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = (prescaler == TICK_DIV-1).
- Digit index:
  - On tick, idx advances by 1.
  - On tick with idx == NUM_DIGITS-1, idx wraps to 0. This is the frame boundary.
- Load:
  - When load = 1, pend_val <= value, pend_dp <= dp_in, pend_flag <= 1.
  - A load while pend_flag = 1 overwrites the pending buffer; the last load wins.
- Commit:
  - At the frame boundary with pend_flag = 1: disp_val <= pend_val, disp_dp <= pend_dp, pend_flag <= 0.
  - If load coincides with the boundary, the old pending contents commit, the new value goes into pending, and pend_flag stays 1.
- frame_done is registered: high for exactly the one cycle after each boundary tick.
- Outputs are registered from idx, disp_val, disp_dp, blank_lz and enable, so they reflect the new idx one cycle after idx changes.
  - SSEG_AN: bit idx = 0, all other bits = 1. When enable = 0, SSEG_AN = all 1s and SSEG_CA = 8'hFF.
- Decode: standard hex glyphs ('b' and 'd' lowercase). CA values with DP off:
  - 0 -> C0, 1 -> F9, 2 -> A4, 3 -> B0, 4 -> 99, 5 -> 92, 6 -> 82, 7 -> F8
  - 8 -> 80, 9 -> 90, A -> 88, b -> 83, C -> C6, d -> A1, E -> 86, F -> 8E
- DP: CA[7] = ~disp_dp[idx].
- Leading-zero blanking:
  - With blank_lz = 1, digit i (i > 0) is blank when every nibble from i to NUM_DIGITS-1 is zero.
  - Digit 0 is never blanked.
  - For a blank digit, CA[6:0] = 7'h7F; DP still follows disp_dp. The anode is still driven.
  - blank_lz acts live, not buffered.
- NUM_DIGITS = 1: idx is constant 0 and every tick is a frame boundary.

Optional Feature:
SSEG_DIM_EN
- Defined:
  - Adds input port brightness[3:0] and a free-running 4-bit PWM counter (reset 0, increments every clk).
  - The selected anode is asserted only while pwm_cnt <= brightness; otherwise SSEG_AN = all 1s. Cathodes are unaffected.
  - brightness = 15 gives full on; brightness = 0 gives a 1/16 duty cycle.
  - brightness is sampled live.
- Undefined: the port and counter are absent, and behaviour equals brightness = 15.

Test Plan:
- NUM_DIGITS=4, TICK_DIV=4. Reset, then load value=16'h1234, dp_in=0, enable=1, blank_lz=0. After the first frame boundary, SSEG_AN must cycle E,D,B,7 for 4 cycles each, with CA = 99,B0,A4,F9 (digit 0 shows 4), and frame_done pulses every 16 cycles.
- Double buffering: load 16'h1234, wait one frame, then load 16'hABCD at idx=1. CA for idx 2 and 3 of the current frame must still show 2 and 1. The next frame shows D,C,b,A (A1,C6,83,88). A load in the exact boundary cycle appears one frame later.
- Blanking: load 16'h0050 with blank_lz=1. Digits 3 and 2 must show CA = FF. Digit 1 shows 92 and digit 0 shows C0. Loading 16'h0000 must show digit 0 = C0 and the rest FF.
- DP and enable: load dp_in=4'b0001 with value 16'h8888. Digit 0 must show CA = 00 and the others 80. Driving enable=0 must give SSEG_AN = F and SSEG_CA = FF on the next cycle.
- Reset mid-frame: assert rst at idx=2 with a pending load. The next cycle must show AN = F, CA = FF and frame_done = 0. After release, display 0 (CA = C0 on digit 0); the pending value is lost.
- With SSEG_DIM_EN and brightness=3: the active anode must be low for 4 of every 16 cycles; with brightness=15 it must be always low.
